// File: rtl/pipe_tile.sv
// rtl/pipe_tile.sv - rotatable pipe tile with N/E/S/W connection mask and flow-fill animation
// PIPE_TILE_CROSS_EN adds the cross shape (state 7) to the rotation cycle.
module pipe_tile #(
  parameter int PIPE_W   = 4,
  parameter int ARM_LEN  = 6,
  parameter int FILL_DIV = 100
) (
  input  logic        clk_1khz,
  input  logic        reset_n,
  input  logic [6:0]  tile_dx,
  input  logic [5:0]  tile_dy,
  input  logic [6:0]  x,
  input  logic [5:0]  y,
  input  logic [6:0]  selector_x,
  input  logic [5:0]  selector_y,
  input  logic        pb_next,
  input  logic        pb_prev,
  input  logic        lock,
  input  logic        flow_start,
  input  logic [1:0]  flow_dir,
  input  logic        flow_clear,
  input  logic [15:0] colour,
  input  logic [15:0] fill_colour,
  output logic [15:0] tile_data,
  output logic [2:0]  state,
  output logic [3:0]  conn_mask,
  output logic        fill_done,
  output logic        leak
);

`ifdef PIPE_TILE_CROSS_EN
  localparam logic [2:0] LAST_SHAPE = 3'd7;
`else
  localparam logic [2:0] LAST_SHAPE = 3'd6;
`endif

  localparam int DIV_W = (FILL_DIV > 1) ? $clog2(FILL_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(FILL_DIV - 1);
  localparam logic signed [7:0] PW = 8'(PIPE_W);
  localparam logic signed [7:0] AL = 8'(ARM_LEN);

  typedef enum logic [1:0] {IDLE, FILLING, FULL} fill_st_e;

  fill_st_e         fsm_q, fsm_d;
  logic [2:0]       state_q, state_d;
  logic [1:0]       level_q, level_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             leak_q, leak_d;
  logic [1:0]       entry_q, entry_d;
  logic             pb_next_prev_q, pb_next_prev_d;
  logic             pb_prev_prev_q, pb_prev_prev_d;

  function automatic logic in_rng(input logic signed [7:0] v,
                                  input logic signed [7:0] lo,
                                  input logic signed [7:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Everything is widened to 8-bit signed so arms left/above the screen clip instead of wrapping.
  logic signed [7:0] px, py, dx, dy, sx, sy;
  assign px = signed'({1'b0, x});
  assign py = signed'({2'b00, y});
  assign dx = signed'({1'b0, tile_dx});
  assign dy = signed'({2'b00, tile_dy});
  assign sx = signed'({1'b0, selector_x});
  assign sy = signed'({2'b00, selector_y});

  logic core_x, core_y, in_core;
  logic [3:0] arm_hit;
  logic hit;

  always_comb begin
    core_x     = in_rng(px, dx, dx + PW - 8'sd1);
    core_y     = in_rng(py, dy, dy + PW - 8'sd1);
    in_core    = core_x && core_y;
    arm_hit[3] = core_x && in_rng(py, dy - AL, dy - 8'sd1);
    arm_hit[2] = core_y && in_rng(px, dx + PW, dx + PW + AL - 8'sd1);
    arm_hit[1] = core_x && in_rng(py, dy + PW, dy + PW + AL - 8'sd1);
    arm_hit[0] = core_y && in_rng(px, dx - AL, dx - 8'sd1);
    hit        = in_rng(sx, dx - AL, dx + PW + AL - 8'sd1) &&
                 in_rng(sy, dy - AL, dy + PW + AL - 8'sd1);
  end

  logic [3:0] mask;
  always_comb begin
    case (state_q)
      3'd1:    mask = 4'b1010;
      3'd2:    mask = 4'b0101;
      3'd3:    mask = 4'b1100;
      3'd4:    mask = 4'b1001;
      3'd5:    mask = 4'b0011;
      3'd6:    mask = 4'b0110;
`ifdef PIPE_TILE_CROSS_EN
      3'd7:    mask = 4'b1111;
`endif
      default: mask = 4'b0000;
    endcase
  end

  logic [3:0] entry_bit, start_bit, fill_arms;
  logic in_shape, in_fill;

  always_comb begin
    entry_bit = 4'b1000 >> entry_q;
    start_bit = 4'b1000 >> flow_dir;
    fill_arms = ((level_q >= 2'd1) ? entry_bit : 4'b0000) |
                ((level_q == 2'd3) ? (mask & ~entry_bit) : 4'b0000);
    in_shape  = (in_core && (mask != 4'b0000)) || (|(arm_hit & mask));
    in_fill   = (in_core && (level_q >= 2'd2) && (mask != 4'b0000)) ||
                (|(arm_hit & mask & fill_arms));
    if (in_fill)       tile_data = fill_colour;
    else if (in_shape) tile_data = colour;
    else               tile_data = 16'h0000;
  end

  logic next_rise, prev_rise, rot_en;

  always_comb begin
    next_rise      = pb_next && !pb_next_prev_q;
    prev_rise      = pb_prev && !pb_prev_prev_q;
    rot_en         = hit && !lock && (fsm_q == IDLE);
    state_d        = state_q;
    fsm_d          = fsm_q;
    level_d        = level_q;
    div_d          = div_q;
    leak_d         = 1'b0;
    entry_d        = entry_q;
    pb_next_prev_d = pb_next;
    pb_prev_prev_d = pb_prev;

    if (rot_en && next_rise && !prev_rise)
      state_d = (state_q >= LAST_SHAPE) ? 3'd0 : state_q + 3'd1;
    else if (rot_en && prev_rise && !next_rise)
      state_d = (state_q == 3'd0 || state_q > LAST_SHAPE) ? LAST_SHAPE : state_q - 3'd1;

    if (flow_clear) begin
      fsm_d   = IDLE;
      level_d = 2'd0;
      div_d   = '0;
    end else begin
      case (fsm_q)
        IDLE: if (flow_start) begin
          if (|(mask & start_bit)) begin
            fsm_d   = FILLING;
            level_d = 2'd0;
            div_d   = '0;
            entry_d = flow_dir;
          end else begin
            leak_d  = 1'b1;
          end
        end
        FILLING: begin
          if (div_q == DIV_MAX) begin
            div_d   = '0;
            level_d = level_q + 2'd1;
            if (level_q == 2'd2) fsm_d = FULL;
          end else begin
            div_d   = div_q + 1'b1;
          end
        end
        FULL:    fsm_d = FULL;
        default: fsm_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_1khz) begin
    if (!reset_n) begin
      state_q        <= 3'd0;
      fsm_q          <= IDLE;
      level_q        <= 2'd0;
      div_q          <= '0;
      leak_q         <= 1'b0;
      entry_q        <= 2'd0;
      pb_next_prev_q <= 1'b1;
      pb_prev_prev_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      fsm_q          <= fsm_d;
      level_q        <= level_d;
      div_q          <= div_d;
      leak_q         <= leak_d;
      entry_q        <= entry_d;
      pb_next_prev_q <= pb_next_prev_d;
      pb_prev_prev_q <= pb_prev_prev_d;
    end
  end

  assign state     = state_q;
  assign conn_mask = mask;
  assign fill_done = (fsm_q == FULL);
  assign leak      = leak_q;

endmodule

// File: doc/pipe_tile.md
# pipe_tile

Parametrised, rotatable pipe tile for the flow game on the 96x64 OLED. It generalises the fixed-size vertical tile in three ways: pipe width and arm length are parameters, rotation can step forwards or backwards, and a selectable cross shape is available. Each tile publishes its N/E/S/W connection mask to the board solver. A segment-by-segment flow-fill animation runs when the solver pushes water into the tile. One instance sits per board cell, and its pixel output is OR-muxed into the frame data.

## Interface
Parameters:
- PIPE_W, default 4: pipe thickness and core square side, in pixels.
- ARM_LEN, default 6: length of each arm beyond the core, in pixels.
- FILL_DIV, default 100: clk_1khz cycles per fill step (100 ms).

Ports:
- clk_1khz  in  1  sole clock.
- reset_n  in  1  synchronous, active-low reset.
- tile_dx  in  7  core top-left x.
- tile_dy  in  6  core top-left y.
- x  in  7  pixel x being rendered.
- y  in  6  pixel y being rendered.
- selector_x  in  7  cursor x.
- selector_y  in  6  cursor y.
- pb_next  in  1  rotate forward (rising edge).
- pb_prev  in  1  rotate backward (rising edge).
- lock  in  1  tile fixed; rotation ignored.
- flow_start  in  1  one-cycle pulse that begins the fill.
- flow_dir  in  2  entry side: 0=N, 1=E, 2=S, 3=W.
- flow_clear  in  1  abort or clear the fill.
- colour  in  16  RGB565 pipe colour.
- fill_colour  in  16  RGB565 water colour.
- tile_data  out  16  pixel colour for (x, y).
- state  out  3  shape index.
- conn_mask  out  4  {N,E,S,W} openings.
- fill_done  out  1  high while FULL.
- leak  out  1  one-cycle pulse: entry side closed.

## Operation
- Shapes (state, then conn_mask): 0 empty 0000; 1 vertical 1010; 2 horizontal 0101; 3 NE 1100; 4 NW 1001; 5 SW 0011; 6 SE 0110; 7 cross 1111 (only with the macro, see Configuration).
- Geometry:
  - Core: [dx, dx+PIPE_W-1] × [dy, dy+PIPE_W-1].
  - N arm: same x range as the core; y in [dy-ARM_LEN, dy-1].
  - S arm: y in [dy+PIPE_W, dy+PIPE_W+ARM_LEN-1].
  - W arm and E arm: same y range as the core, mirrored in x.
  - All comparisons use 8-bit signed arithmetic. Arm pixels off-screen are clipped, never wrapped.
- Selection: hit is true when the selector lies inside the bounding box [dx-ARM_LEN, dx+PIPE_W+ARM_LEN-1] × [dy-ARM_LEN, dy+PIPE_W+ARM_LEN-1].
- Rotation is enabled only when all of these hold: hit, !lock, fill FSM in IDLE.
  - pb_next rising edge: state+1, wrapping from the last shape to 0.
  - pb_prev rising edge: state-1, wrapping from 0 to the last shape.
  - Both edges in the same cycle: no change.
- Fill FSM, states IDLE, FILLING, FULL:
  - IDLE → FILLING on flow_start, when state≠0 and conn_mask[entry] = 1. Clears fill_level and the divider.
  - IDLE on flow_start with the entry side closed, or with state 0: pulse leak for 1 cycle, stay in IDLE.
  - FILLING: fill_level steps 1→2→3, one step each FILL_DIV cycles. Level 1 fills the entry arm, level 2 the core, level 3 every other open arm. On reaching 3, go to FULL.
  - FULL holds until flow_clear.
  - flow_clear from any state → IDLE and fill_level 0. flow_clear has priority over flow_start.
  - flow_start while FILLING or FULL is ignored.
- Render priority: pixel in a filled segment → fill_colour; else pixel in shape → colour; else 0.

## Timing
- Reset (reset_n low at a clock edge) sets:
  - state 0, FSM IDLE, fill_level 0, divider 0, leak 0.
  - Previous-button registers to 1, so a button held through reset is not counted.
- The reset result is visible the cycle after the reset edge.
- Reset mid-fill aborts the fill immediately.
- Rotation: state changes on the edge after the button's rising sample, i.e. 1 cycle after pb goes high.
- tile_data, conn_mask and state are combinational from registers, with zero latency relative to x, y.
- fill_done rises FILL_DIV×3 cycles after the cycle flow_start is sampled.
- leak asserts the cycle after flow_start.

## Configuration
- PIPE_TILE_CROSS_EN defined: the cross shape (state 7, mask 1111) is in the rotation cycle. Its last shape is 7, and a fill drives every non-entry arm at level 3.
- Undefined: the last shape is 6 and state 7 is unreachable. If state ever reads 7, render 0 and mask 0000.

## Test plan
- Reset, selector inside the bbox, 7 pb_next edges (macro off) → state goes 1,2,3,4,5,6,0. Then one pb_prev edge → state 6.
- Selector outside the bbox, or lock=1, with a pb_next edge → state unchanged. pb_next and pb_prev rising in the same cycle → unchanged.
- state=1, flow_dir=0, flow_start, FILL_DIV=4:
  - 4 cycles later, the N arm renders fill_colour.
  - At 8 cycles, the core renders fill_colour.
  - At 12 cycles, fill_done=1. During this, pb_next does not change state.
- state=2, flow_dir=0, flow_start → leak is high for exactly 1 cycle and the FSM stays IDLE. state=0 with flow_start → leak.
- FILLING at level 2, then reset_n=0 for 1 cycle → state 0, tile_data 0, fill_done 0. The same abort with flow_clear keeps state and returns to IDLE.
- Macro on: the cycle from 6 goes → 7 (conn_mask 1111) → 0. tile_dx=2, W arm → no pixels drawn at wrapped x ≥ 90.
